instr_fetch: RTL and testbench

- Fetch-side initiator that drives the address into instr_mem and consumes its registered 8-bit instruction output.
- Owns the program counter and tracks the one-cycle in-flight read.
- Hands a registered, tagged instruction to decode; supports stall (with replay), branch/jump redirect and halt detection.
- Sits between instr_mem and the decode/control stage of the 8-bit MIPS core.

---
 rtl/core_pkg.sv | 8 +
 rtl/instr_fetch_if.sv | 23 ++
 rtl/instr_fetch.sv | 56 +++++
 tb/tb_instr_fetch.sv | 137 +++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, reset/halt encodings and fetch state encoding for the 8-bit core.
package core_pkg;
  localparam int PC_W = 8;
  localparam int INSTR_W = 8;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 8'hFF;
  typedef enum logic [1:0] {RUN, STALL, HALTED} fetch_state_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch <-> instr_mem / decode signal bundle.
interface instr_fetch_if #(
  parameter int PC_W = core_pkg::PC_W,
  parameter int INSTR_W = core_pkg::INSTR_W
);
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] instruction;
  logic stall;
  logic redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0] instr_pc;
  logic instr_valid;
  logic halted;
  modport master (
    output pc, instr_out, instr_pc, instr_valid, halted,
    input instruction, stall, redirect, redirect_pc
  );
  modport slave (
    input pc, instr_out, instr_pc, instr_valid, halted,
    output instruction, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: pc owner with one-cycle in-flight tag, stall replay, redirect and halt detection.
module instr_fetch #(
  parameter int PC_W = core_pkg::PC_W,
  parameter int INSTR_W = core_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = core_pkg::RESET_PC,
  parameter bit HALT_EN = 1'b1,
  parameter logic [INSTR_W-1:0] HALT_INSTR = core_pkg::HALT_INSTR
) (
  input logic clk,
  input logic reset_n,
  instr_fetch_if.master bus
);
  import core_pkg::*;
  localparam logic [1:0] S_RUN = RUN;
  localparam logic [1:0] S_STALL = STALL;
  localparam logic [1:0] S_HALT = HALTED;
  logic [1:0] st, st_n;
  logic [PC_W-1:0] pc, pc_n, d_pc, ipc;
  logic [INSTR_W-1:0] out;
  logic d_v, v, v_n, hlt, run, hit;
  assign hlt = st == S_HALT;
  assign run = !bus.redirect && !hlt && !bus.stall;
  assign hit = HALT_EN && d_v && bus.instruction == HALT_INSTR;
  // a stalled fetch whose data was never consumed is reissued from its tag
  always_comb begin
    st_n = bus.redirect ? S_RUN : hlt ? S_HALT : bus.stall ? S_STALL : hit ? S_HALT : S_RUN;
    pc_n = bus.redirect ? bus.redirect_pc : run ? pc + 1'b1 : (!hlt && d_v) ? d_pc : pc;
    v_n = bus.redirect || hlt ? 1'b0 : bus.stall ? v : d_v;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
      d_pc <= '0;
      d_v <= 1'b0;
      out <= '0;
      ipc <= '0;
      v <= 1'b0;
      st <= S_RUN;
    end else begin
      pc <= pc_n;
      st <= st_n;
      v <= v_n;
      d_v <= run;
      if (run) begin
        d_pc <= pc;
        out <= bus.instruction;
        ipc <= d_pc;
      end
    end
  end
  assign bus.pc = pc;
  assign bus.instr_out = out;
  assign bus.instr_pc = ipc;
  assign bus.instr_valid = v;
  assign bus.halted = hlt;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: cycle table for instr_fetch plus a scoreboard of instructions accepted by decode.
module tb_instr_fetch;
  import core_pkg::*;
  typedef struct packed {
    logic st;
    logic rd;
    logic [7:0] rpc;
    logic v;
    logic [7:0] out;
    logic [7:0] ipc;
    logic [7:0] pc;
    logic h;
  } vec_t;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  instr_fetch_if bus();
  instr_fetch dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] rom [256];
  always @(posedge clk) bus.instruction <= rom[bus.pc];
  vec_t tbl [27];
  logic [15:0] q [$];
  int checks = 0;
  int errors = 0;
  logic pv;
  logic [15:0] pd;

  function automatic vec_t mk(input logic st, input logic rd, input logic [7:0] rpc, input logic v,
                              input logic [7:0] out, input logic [7:0] ipc, input logic [7:0] pc, input logic h);
    return '{st, rd, rpc, v, out, ipc, pc, h};
  endfunction

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic rst_chk(input string n);
    chk({n, "_valid"}, {7'd0, bus.instr_valid}, 8'h00);
    chk({n, "_halted"}, {7'd0, bus.halted}, 8'h00);
    chk({n, "_out"}, bus.instr_out, 8'h00);
    chk({n, "_ipc"}, bus.instr_pc, 8'h00);
    chk({n, "_pc"}, bus.pc, RESET_PC);
  endtask

  // decode accepts instr_out whenever it is valid and not stalled
  task automatic step(input int i, input vec_t r);
    logic [15:0] e;
    string n;
    n = $sformatf("r%0d", i);
    bus.stall = r.st;
    bus.redirect = r.rd;
    bus.redirect_pc = r.rpc;
    if (pv && !r.st) q.push_back(pd);
    @(negedge clk);
    if (bus.instr_valid && !bus.stall) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_extra got=%h/%h want=none", n, bus.instr_out, bus.instr_pc);
      end else begin
        e = q.pop_front();
        chk({n, "_sb_instr"}, bus.instr_out, e[15:8]);
        chk({n, "_sb_pc"}, bus.instr_pc, e[7:0]);
      end
    end
    @(posedge clk);
    #1;
    chk({n, "_valid"}, {7'd0, bus.instr_valid}, {7'd0, r.v});
    chk({n, "_halted"}, {7'd0, bus.halted}, {7'd0, r.h});
    chk({n, "_pc"}, bus.pc, r.pc);
    if (r.v) begin
      chk({n, "_out"}, bus.instr_out, r.out);
      chk({n, "_ipc"}, bus.instr_pc, r.ipc);
    end
    pv = r.v;
    pd = {r.out, r.ipc};
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h40 + 8'(i % 64);
    rom[0] = 8'h01; rom[1] = 8'h2E; rom[2] = 8'h3E; rom[3] = 8'hFF;
    rom[5] = 8'h29; rom[8'hFE] = 8'hA1; rom[8'hFF] = 8'hA2;
    tbl[0]  = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'h01, N);
    tbl[1]  = mk(N, N, 8'h00, Y, 8'h01, 8'h00, 8'h02, N);
    tbl[2]  = mk(N, N, 8'h00, Y, 8'h2E, 8'h01, 8'h03, N);
    tbl[3]  = mk(Y, N, 8'h00, Y, 8'h2E, 8'h01, 8'h02, N);
    tbl[4]  = mk(Y, N, 8'h00, Y, 8'h2E, 8'h01, 8'h02, N);
    tbl[5]  = mk(Y, N, 8'h00, Y, 8'h2E, 8'h01, 8'h02, N);
    tbl[6]  = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'h03, N);
    tbl[7]  = mk(N, N, 8'h00, Y, 8'h3E, 8'h02, 8'h04, N);
    tbl[8]  = mk(Y, Y, 8'h05, N, 8'h00, 8'h00, 8'h05, N);
    tbl[9]  = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'h06, N);
    tbl[10] = mk(N, N, 8'h00, Y, 8'h29, 8'h05, 8'h07, N);
    tbl[11] = mk(N, Y, 8'h03, N, 8'h00, 8'h00, 8'h03, N);
    tbl[12] = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'h04, N);
    tbl[13] = mk(N, N, 8'h00, Y, 8'hFF, 8'h03, 8'h05, Y);
    tbl[14] = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'h05, Y);
    tbl[15] = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'h05, Y);
    tbl[16] = mk(Y, N, 8'h00, N, 8'h00, 8'h00, 8'h05, Y);
    tbl[17] = mk(N, Y, 8'h00, N, 8'h00, 8'h00, 8'h00, N);
    tbl[18] = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'h01, N);
    tbl[19] = mk(N, N, 8'h00, Y, 8'h01, 8'h00, 8'h02, N);
    tbl[20] = mk(N, Y, 8'hFE, N, 8'h00, 8'h00, 8'hFE, N);
    tbl[21] = mk(N, N, 8'h00, N, 8'h00, 8'h00, 8'hFF, N);
    tbl[22] = mk(N, N, 8'h00, Y, 8'hA1, 8'hFE, 8'h00, N);
    tbl[23] = mk(N, N, 8'h00, Y, 8'hA2, 8'hFF, 8'h01, N);
    tbl[24] = mk(N, N, 8'h00, Y, 8'h01, 8'h00, 8'h02, N);
    tbl[25] = mk(N, N, 8'h00, Y, 8'h2E, 8'h01, 8'h03, N);
    tbl[26] = mk(Y, N, 8'h00, Y, 8'h2E, 8'h01, 8'h02, N);
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 8'h00;
    pv = 1'b0;
    pd = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_chk("rst");
    #1 reset_n = 1'b1;
    for (int i = 0; i < 27; i++) step(i, tbl[i]);
    #2 reset_n = 1'b0;
    #1;
    rst_chk("arst");
    pv = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(100 + i, tbl[i]);
    chk("sb_left", 8'(q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
